// File: rtl/ppc_pkg.sv
// ppc_pkg: widths and types shared by the fetch, instruction-queue and decode
// stages of the PPC core. Bit numbering is big-endian (bit 0 is the MSB),
// matching the architecture manuals.
//
// Contents:
//   INST_W / FETCH_W / ADDR_W  instruction, fetch doubleword and address widths
//   WADDR_W                    word-address width (byte address without [62:63])
//   ENTRY_W                    width of one queue entry (instruction + word address)
//   inst_t, pc_t, fetch_word_t, word_addr_t, iq_entry_t
//   wordToPc()                 rebuilds a byte address from a word address
package ppc_pkg;

    localparam int INST_W  = 32;
    localparam int FETCH_W = 64;
    localparam int ADDR_W  = 64;
    localparam int WADDR_W = ADDR_W - 2;
    localparam int ENTRY_W = INST_W + WADDR_W;

    typedef logic [0:INST_W-1]  inst_t;
    typedef logic [0:ADDR_W-1]  pc_t;
    typedef logic [0:FETCH_W-1] fetch_word_t;
    typedef logic [0:WADDR_W-1] word_addr_t;

    // One queue slot. Only the word address is kept: instructions are
    // word-aligned, so pc[62:63] is always zero and need not be stored.
    typedef struct packed {
        inst_t      inst;
        word_addr_t wordAddr;
    } iq_entry_t;

    function automatic pc_t wordToPc(input word_addr_t wordAddr);
        return {wordAddr, 2'b00};
    endfunction

endpackage

// File: rtl/iq_storage.sv
// iq_storage: DEPTH-entry register array backing the instruction queue.
//
// Ports:
//   clk      core clock; writes land on posedge
//   wrEn0    write enable for port 0 (slot at tail)
//   wrAddr0  port 0 slot index
//   wrData0  port 0 entry {inst, wordAddr}
//   wrEn1    write enable for port 1 (slot at tail+1)
//   wrAddr1  port 1 slot index
//   wrData1  port 1 entry {inst, wordAddr}
//   rdAddr   read slot index (head)
//   rdData   entry at rdAddr, combinational
//
// The array is intentionally not reset; the owning queue only ever reads
// slots its count says are occupied. The two write ports are never given the
// same address by the owner, so their relative order in the block is moot.
module iq_storage
    import ppc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic               clk,
    input  logic               wrEn0,
    input  logic [PTR_W-1:0]   wrAddr0,
    input  logic [0:ENTRY_W-1] wrData0,
    input  logic               wrEn1,
    input  logic [PTR_W-1:0]   wrAddr1,
    input  logic [0:ENTRY_W-1] wrData1,
    input  logic [PTR_W-1:0]   rdAddr,
    output logic [0:ENTRY_W-1] rdData
);

    logic [0:ENTRY_W-1] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn0) begin
            mem[wrAddr0] <= wrData0;
        end
        if (wrEn1) begin
            mem[wrAddr1] <= wrData1;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/inst_dispatch_queue.sv
// inst_dispatch_queue: instruction queue between fetch and decode.
//
// Fetch delivers 64-bit doublewords (two instructions); this block stores
// them in program order and presents one instruction per cycle, with its PC,
// to decode. A branch redirect (flush) empties the queue synchronously.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   fetch_valid  fetch offers a doubleword
//   fetch_ready  queue can take a doubleword (room for two slots)
//   fetch_data   doubleword; [0:31] lower-address instruction, [32:63] higher
//   fetch_pc     byte address of first valid instruction; [61] picks the word
//   disp_valid   an instruction is presented to decode
//   disp_ready   decode consumes the presented instruction
//   disp_inst    instruction at head (0 when disp_valid=0)
//   disp_pc      byte address of disp_inst (0 when disp_valid=0)
//   flush        discard all queued instructions at this edge
//   level        number of occupied slots, 0..DEPTH
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. fetch_ready depends only on queue occupancy, reset and flush (never
// on disp_ready), and disp_valid only on occupancy and flush, so neither side
// sees a combinational path from the other side's handshake.
module inst_dispatch_queue
    import ppc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [0:FETCH_W-1] fetch_data,
    input  logic [0:ADDR_W-1]  fetch_pc,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic [0:INST_W-1]  disp_inst,
    output logic [0:ADDR_W-1]  disp_pc,
    input  logic               flush,
    output logic [0:PTR_W]     level
);

    // A doubleword may need two slots, so accept only while two are free.
    localparam logic [PTR_W:0] ENQ_LIMIT = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic       canEnq;
    logic       enqAccept;
    logic       oddStart;
    logic [1:0] nEnq;
    logic       dispValid;
    logic       deq;

    word_addr_t fetchWord;
    word_addr_t nextWord;
    iq_entry_t  wrEntry0;
    iq_entry_t  wrEntry1;
    iq_entry_t  rdEntry;

    // Byte-offset bits of the fetch address carry no information.
    logic unusedPcBits;
    assign unusedPcBits = ^fetch_pc[62:63];

    // ---------------- enqueue side ----------------
    assign canEnq      = rst_n & ~flush & (count <= ENQ_LIMIT);
    assign fetch_ready = canEnq;
    assign enqAccept   = fetch_valid & canEnq;

    // A branch target in the odd word means the even word is not on the
    // program path and must be dropped.
    assign oddStart  = fetch_pc[61];
    assign fetchWord = fetch_pc[0:61];
    assign nextWord  = fetchWord + WADDR_W'(1);

    always_comb begin
        wrEntry0.wordAddr = fetchWord;
        wrEntry0.inst     = oddStart ? fetch_data[32:63] : fetch_data[0:31];
        wrEntry1.wordAddr = nextWord;
        wrEntry1.inst     = fetch_data[32:63];
    end

    always_comb begin
        nEnq = 2'd0;
        if (enqAccept) begin
            nEnq = oddStart ? 2'd1 : 2'd2;
        end
    end

    // ---------------- dispatch side ----------------
    assign dispValid  = (count != '0) & ~flush;
    assign deq        = dispValid & disp_ready;
    assign disp_valid = dispValid;
    assign disp_inst  = dispValid ? rdEntry.inst : '0;
    assign disp_pc    = dispValid ? wordToPc(rdEntry.wordAddr) : '0;

    // ---------------- storage ----------------
    iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wrEn0   (enqAccept),
        .wrAddr0 (tail),
        .wrData0 (wrEntry0),
        .wrEn1   (enqAccept & ~oddStart),
        .wrAddr1 (tail + PTR_W'(1)),
        .wrData1 (wrEntry1),
        .rdAddr  (head),
        .rdData  (rdEntry)
    );

    // ---------------- pointers and occupancy ----------------
    // Flush wins over any handshake; canEnq/dispValid are already forced low
    // by flush, so the clear here cannot race an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + PTR_W'(nEnq);
            count <= count + {{(PTR_W-1){1'b0}}, nEnq} - {{PTR_W{1'b0}}, deq};
        end
    end

    assign level = count;

endmodule
